// File: rtl/decoder_3x8_seq.sv
// Sequenced 3:8 decoder: buffers {en,code} in a FIFO and replays each
// code as a registered one-hot strobe for HOLD_CYCLES, then GAP_CYCLES
// of zero before the next code.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     code handshake; transfer when both high
//   in_code, in_en        code to decode; in_en=0 gives a blank slot
//   out, out_valid        registered one-hot word, high during HOLD
//   busy                  FSM active or FIFO non-empty
//   fifo_level            number of buffered codes
module decoder_3x8_seq #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [2:0]                    in_code,
   input  logic                          in_en,
   output logic                          in_ready,
   output logic [7:0]                    out,
   output logic                          out_valid,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_M1 =
      (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam bit HAS_GAP = (GAP_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   // FIFO storage: entry = {en, code}
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [3:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   // Sequencer state
   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    out_q, out_d;
   logic          out_valid_q, out_valid_d;

   logic          push;
   logic          pop;
   logic          empty;
   logic          load;
   logic [3:0]    head;

   function automatic logic [7:0] decode(input logic [3:0] ent);
      logic [7:0] w;
      w = 8'h00;
      if (ent[3]) begin
         w[ent[2:0]] = 1'b1;
      end
      return w;
   endfunction

   // in_ready looks only at the registered level, so a pop in
   // the same cycle never opens the door for a push.
   assign in_ready   = (level_q != FULL_LVL);
   assign push       = in_valid & in_ready;
   assign empty      = (level_q == '0);
   assign head       = mem_q[rd_ptr_q];

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign fifo_level = level_q;
   assign busy       = (state_q != IDLE) | ~empty;

   // Sequencer next state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      load        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               load = 1'b1;
            end else begin
               out_d       = 8'h00;
               out_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (HAS_GAP) begin
               out_d       = 8'h00;
               out_valid_d = 1'b0;
               cnt_d       = GAP_M1;
               state_d     = GAP;
            end else if (!empty) begin
               // no gap: next word follows with no zero cycle
               load = 1'b1;
            end else begin
               out_d       = 8'h00;
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         GAP: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!empty) begin
               load = 1'b1;
            end else begin
               out_d       = 8'h00;
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_d       = 8'h00;
            out_valid_d = 1'b0;
            cnt_d       = 8'd0;
            state_d     = IDLE;
         end
      endcase

      if (load) begin
         out_d       = decode(head);
         out_valid_d = 1'b1;
         cnt_d       = HOLD_M1;
         state_d     = HOLD;
      end
   end

   assign pop = load;

   // FIFO next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push) begin
         mem_d[wr_ptr_q] = {in_en, in_code};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= 4'h0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         out_q       <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: two instances (HOLD=4/GAP=1 and
// HOLD=1/GAP=0) checked every cycle against a slot-timeline model.
module tb_decoder_3x8_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       iv_a, ie_a, rdy_a, ov_a, bz_a;
   logic [2:0] ic_a, lv_a;
   logic [7:0] ow_a;

   logic       iv_b, ie_b, rdy_b, ov_b, bz_b;
   logic [2:0] ic_b, lv_b;
   logic [7:0] ow_b;

   decoder_3x8_seq #(
      .HOLD_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv_a), .in_code(ic_a), .in_en(ie_a),
      .in_ready(rdy_a), .out(ow_a), .out_valid(ov_a),
      .busy(bz_a), .fifo_level(lv_a)
   );

   decoder_3x8_seq #(
      .HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv_b), .in_code(ic_b), .in_en(ie_b),
      .in_ready(rdy_b), .out(ow_b), .out_valid(ov_b),
      .busy(bz_b), .fifo_level(lv_b)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: every accepted code owns a slot starting at edge
   // max(push_edge+1, prev_start+HOLD+GAP); it drives its word for
   // HOLD edges and keeps the unit busy for HOLD+GAP edges.
   int HP [2] = '{4, 1};
   int GP [2] = '{1, 0};
   int cyc = 0;
   int nslot [2];
   int last [2];
   int st [2][1024];
   logic [7:0] wd [2][1024];

   function automatic int nxt_start(input int k, input int e);
      int a;
      int b;
      a = e + 1;
      b = last[k] + HP[k] + GP[k];
      return (a > b) ? a : b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nslot[0] <= 0;
         nslot[1] <= 0;
         last[0]  <= -1000;
         last[1]  <= -1000;
      end else begin
         cyc <= cyc + 1;
         if (iv_a && rdy_a) begin
            st[0][nslot[0]] <= nxt_start(0, cyc + 1);
            wd[0][nslot[0]] <= ie_a ? 8'(1 << ic_a) : 8'h00;
            last[0]         <= nxt_start(0, cyc + 1);
            nslot[0]        <= nslot[0] + 1;
         end
         if (iv_b && rdy_b) begin
            st[1][nslot[1]] <= nxt_start(1, cyc + 1);
            wd[1][nslot[1]] <= ie_b ? 8'(1 << ic_b) : 8'h00;
            last[1]         <= nxt_start(1, cyc + 1);
            nslot[1]        <= nslot[1] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            logic [7:0] eo, ao;
            logic       ev, eb, av, ab, ar;
            int         el, al;
            string      p;
            eo = 8'h00; ev = 1'b0; eb = 1'b0; el = 0;
            for (int i = 0; i < nslot[k]; i++) begin
               if (st[k][i] > cyc) begin
                  el++;
               end else if (cyc < st[k][i] + HP[k]) begin
                  eo = wd[k][i]; ev = 1'b1; eb = 1'b1;
               end else if (cyc < st[k][i] + HP[k] + GP[k]) begin
                  eb = 1'b1;
               end
            end
            if (el > 0) eb = 1'b1;
            if (k == 0) begin
               ao = ow_a; av = ov_a; ab = bz_a; ar = rdy_a; al = int'(lv_a);
               p = "a";
            end else begin
               ao = ow_b; av = ov_b; ab = bz_b; ar = rdy_b; al = int'(lv_b);
               p = "b";
            end
            check({p, "_out"}, int'(ao), int'(eo));
            check({p, "_out_valid"}, int'(av), int'(ev));
            check({p, "_busy"}, int'(ab), int'(eb));
            check({p, "_level"}, al, el);
            check({p, "_in_ready"}, int'(ar), int'(el != 4));
            check({p, "_onehot0"}, int'($onehot0(ao)), 1);
         end
      end
   end

   // Observation helpers for the literal checks
   logic saw_full = 1'b0;
   logic pv_a = 1'b0;
   logic [7:0] po_a = 8'h00;
   logic [7:0] seen_a [$];
   logic rec_b = 1'b0;
   logic [7:0] hist_b [$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (lv_a == 3'd4 && !rdy_a) saw_full <= 1'b1;
         if (ov_a && (!pv_a || ow_a != po_a)) seen_a.push_back(ow_a);
         pv_a <= ov_a;
         po_a <= ow_a;
         if (rec_b) hist_b.push_back(ow_b);
      end
   end

   task automatic push(input int k, input int code, input bit en);
      bit done;
      done = 1'b0;
      @(negedge clk);
      if (k == 0) begin
         iv_a = 1'b1; ic_a = 3'(code); ie_a = en;
      end else begin
         iv_b = 1'b1; ic_b = 3'(code); ie_b = en;
      end
      for (int n = 0; n < 200 && !done; n++) begin
         @(posedge clk);
         done = (k == 0) ? rdy_a : rdy_b;
      end
      if (!done) check("push_timeout", 0, 1);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      iv_a = 1'b0;
      iv_b = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge clk);
         done = !bz_a && !bz_b;
      end
      if (!done) check("drain_timeout", 0, 1);
      @(negedge clk);
   endtask

   logic [7:0] t4_exp [6];
   int t4_code [6];

   initial begin
      t4_code = '{2, 7, 1, 4, 6, 3};
      t4_exp  = '{8'h04, 8'h80, 8'h02, 8'h10, 8'h40, 8'h08};
      rst_n = 1'b0;
      iv_a = 1'b0; ic_a = 3'd0; ie_a = 1'b0;
      iv_b = 1'b0; ic_b = 3'd0; ie_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", int'(ow_a), 0);
      check("rst_out_valid", int'(ov_a), 0);
      check("rst_level", int'(lv_a), 0);
      check("rst_in_ready", int'(rdy_a), 1);
      check("rst_busy", int'(bz_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single word: 08 for 4 cycles, one zero cycle, then idle
      push(0, 3, 1'b1);
      drop_valid();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("t2_out_%0d", i), int'(ow_a), (i <= 4) ? 8 : 0);
      end
      @(negedge clk);
      check("t2_idle", int'(bz_a), 0);

      // blank slot: out stays zero, out_valid high for 4 cycles
      push(0, 7, 1'b0);
      drop_valid();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("t6_valid_%0d", i), int'(ov_a), 1);
         check($sformatf("t6_out_%0d", i), int'(ow_a), 0);
      end
      @(negedge clk);
      check("t6_valid_end", int'(ov_a), 0);
      drain();

      // all codes back-to-back
      for (int c = 0; c < 8; c++) push(0, c, 1'b1);
      drop_valid();
      check("t3_full_seen", int'(saw_full), 1);
      drain();

      // held valid while stalled: order preserved, none lost
      seen_a.delete();
      for (int i = 0; i < 6; i++) push(0, t4_code[i], 1'b1);
      drop_valid();
      drain();
      check("t4_count", seen_a.size(), 6);
      for (int i = 0; i < 6 && i < seen_a.size(); i++) begin
         check($sformatf("t4_word_%0d", i), int'(seen_a[i]), int'(t4_exp[i]));
      end

      // HOLD=1 GAP=0: 20,40,80 on consecutive cycles
      hist_b.delete();
      rec_b = 1'b1;
      push(1, 5, 1'b1);
      push(1, 6, 1'b1);
      push(1, 7, 1'b1);
      drop_valid();
      repeat (3) @(negedge clk);
      rec_b = 1'b0;
      begin
         int found;
         found = 0;
         for (int i = 0; i + 3 < hist_b.size(); i++) begin
            if (hist_b[i] == 8'h20 && hist_b[i+1] == 8'h40 &&
                hist_b[i+2] == 8'h80 && hist_b[i+3] == 8'h00) found = 1;
         end
         check("t5_consecutive", found, 1);
      end
      drain();

      // random push/stall soak on both instances
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         iv_a = 1'($urandom_range(0, 1));
         ic_a = 3'($urandom_range(0, 7));
         ie_a = ($urandom_range(0, 7) != 0);
         iv_b = 1'($urandom_range(0, 1));
         ic_b = 3'($urandom_range(0, 7));
         ie_b = ($urandom_range(0, 7) != 0);
      end
      drop_valid();
      drain();

      // async reset mid-HOLD with out=20 and two codes queued
      push(0, 5, 1'b1);
      push(0, 1, 1'b1);
      push(0, 2, 1'b1);
      drop_valid();
      check("t1_pre_out", int'(ow_a), 8'h20);
      check("t1_pre_level", int'(lv_a), 2);
      #2 rst_n = 1'b0;
      #1;
      check("t1_out", int'(ow_a), 0);
      check("t1_out_valid", int'(ov_a), 0);
      check("t1_level", int'(lv_a), 0);
      check("t1_in_ready", int'(rdy_a), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_post_out", int'(ow_a), 0);
      check("t1_post_busy", int'(bz_a), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
